// File: rtl/imem_loader.sv
// Boot loader: count header, little-endian words and an XOR checksum arrive as bytes and are
// written into instruction memory; the core stays held until a load verifies.
`default_nettype none

module imem_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    CNT_LO = 3'd0,
    CNT_HI = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  // Largest legal count; 17 bits so that ADDR_W=16 still compares correctly.
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_t      state;
  state_t      next_state;
  logic [15:0] count;
  logic [15:0] idx;
  logic [1:0]  lane;
  logic [23:0] word;
  logic [7:0]  csum;
  logic        accept;
  logic        restart;
  logic [15:0] new_count;

  assign in_ready  = (state != DONE) && (state != ERR);
  assign accept    = in_valid && in_ready;
  assign restart   = start && ((state == DONE) || (state == ERR));
  assign new_count = {in_data, count[7:0]};
  assign done      = (state == DONE);
  assign err       = (state == ERR);
  assign cpu_hold  = (state != DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CNT_LO;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      CNT_LO: if (accept) next_state = CNT_HI;
      CNT_HI: begin
        if (accept) begin
          if ({1'b0, new_count} > MAX_WORDS) next_state = ERR;
          else if (new_count == 16'd0)       next_state = CSUM;
          else                               next_state = DATA;
        end
      end
      DATA: begin
        if (accept && (lane == 2'd3) && ((idx + 16'd1) == count)) next_state = CSUM;
      end
      CSUM: begin
        if (accept) next_state = (in_data == csum) ? DONE : ERR;
      end
      DONE:    if (start) next_state = CNT_LO;
      ERR:     if (start) next_state = CNT_LO;
      default: next_state = CNT_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= 16'd0;
      idx        <= 16'd0;
      lane       <= 2'd0;
      word       <= 24'd0;
      csum       <= 8'd0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'd0;
    end else begin
      imem_we <= 1'b0;
      if (restart) begin
        count     <= 16'd0;
        idx       <= 16'd0;
        lane      <= 2'd0;
        word      <= 24'd0;
        csum      <= 8'd0;
        imem_addr <= BASE_ADDR;
      end else if (accept) begin
        case (state)
          CNT_LO: begin
            count[7:0] <= in_data;
            csum       <= csum ^ in_data;
          end
          CNT_HI: begin
            count[15:8] <= in_data;
            csum        <= csum ^ in_data;
          end
          DATA: begin
            csum <= csum ^ in_data;
            case (lane)
              2'd0: word[7:0]   <= in_data;
              2'd1: word[15:8]  <= in_data;
              2'd2: word[23:16] <= in_data;
              default: begin
                imem_we    <= 1'b1;
                imem_wdata <= {in_data, word};
                imem_addr  <= BASE_ADDR + {14'd0, idx, 2'b00};
                idx        <= idx + 16'd1;
              end
            endcase
            lane <= lane + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued while bytes are driven and
// popped by a monitor on every write strobe.
`default_nettype none

module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0;
  localparam int          MAXN = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;
  int we_count = 0;
  logic [63:0] exp_q[$];

  imem_loader #(.ADDR_W(8), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && imem_we) begin
      logic [63:0] e;
      we_count = we_count + 1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        assert (1'b0) else begin
          errors = errors + 1;
          $error("FAIL sb_unexpected: observed addr=%h data=%h expected no write", imem_addr, imem_wdata);
        end
      end else begin
        e = exp_q.pop_front();
        assert ({imem_addr, imem_wdata} === e) else begin
          errors = errors + 1;
          $error("FAIL sb_write: observed addr=%h data=%h expected addr=%h data=%h",
                 imem_addr, imem_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Builds the expected writes from the stream itself, then drives it with optional idle gaps.
  task automatic send_load(input logic [7:0] bs[$], input int maxgap);
    int n;
    n = (bs.size() >= 2) ? {bs[1], bs[0]} : 0;
    if (n <= MAXN) begin
      for (int i = 0; i < n; i++) begin
        if (2 + 4 * i + 3 < bs.size())
          exp_q.push_back({BASE + 32'(4 * i),
                           bs[5 + 4 * i], bs[4 + 4 * i], bs[3 + 4 * i], bs[2 + 4 * i]});
      end
    end
    for (int j = 0; j < bs.size(); j++) begin
      if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) tick();
      send_byte(bs[j]);
      if (n <= MAXN && j >= 2 && j < 2 + 4 * n && ((j - 2) % 4) == 3)
        chk("we_timing", {31'd0, imem_we}, 32'd1);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] s1[$];
    logic [7:0] s2[$];
    logic [7:0] s4[$];
    logic [7:0] s5[$];
    s1 = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h20, 8'h40, 8'h09, 8'h01, 8'h47};
    s2 = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h20, 8'h40, 8'h09, 8'h01, 8'h48};
    s4 = '{8'h00, 8'h00, 8'h00};
    s5 = '{8'h01, 8'h01};

    #1;
    chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_addr", imem_addr, BASE);
    chk("rst_wdata", imem_wdata, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("idle_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back good load
    we_count = 0;
    send_load(s1, 0);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_hold", {31'd0, cpu_hold}, 32'd0);
    chk("t1_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("t1_writes", we_count, 32'd2);
    chk("t1_sb_empty", exp_q.size(), 32'd0);

    // Bad checksum, then recover
    pulse_start();
    chk("t2_restart_done", {31'd0, done}, 32'd0);
    chk("t2_restart_addr", imem_addr, BASE);
    we_count = 0;
    send_load(s2, 0);
    chk("t2_err", {31'd0, err}, 32'd1);
    chk("t2_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t2_done", {31'd0, done}, 32'd0);
    chk("t2_writes", we_count, 32'd2);
    pulse_start();
    chk("t2_clear_err", {31'd0, err}, 32'd0);
    chk("t2_clear_hold", {31'd0, cpu_hold}, 32'd1);
    send_load(s1, 0);
    chk("t2_done2", {31'd0, done}, 32'd1);
    chk("t2_err2", {31'd0, err}, 32'd0);

    // Random idle gaps
    pulse_start();
    we_count = 0;
    send_load(s1, 5);
    chk("t3_done", {31'd0, done}, 32'd1);
    tick();
    chk("t3_writes", we_count, 32'd2);
    chk("t3_sb_empty", exp_q.size(), 32'd0);

    // Empty program
    pulse_start();
    we_count = 0;
    send_load(s4, 0);
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_hold", {31'd0, cpu_hold}, 32'd0);
    tick();
    chk("t4_writes", we_count, 32'd0);

    // Oversize count
    pulse_start();
    we_count = 0;
    send_load(s5, 0);
    chk("t5_err", {31'd0, err}, 32'd1);
    chk("t5_ready", {31'd0, in_ready}, 32'd0);
    chk("t5_hold", {31'd0, cpu_hold}, 32'd1);
    tick();
    chk("t5_writes", we_count, 32'd0);

    // Reset in the middle of a load
    pulse_start();
    we_count = 0;
    for (int j = 0; j < 5; j++) send_byte(s1[j]);
    rst = 1'b0;
    #1;
    chk("t6_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t6_done", {31'd0, done}, 32'd0);
    chk("t6_err", {31'd0, err}, 32'd0);
    chk("t6_we", {31'd0, imem_we}, 32'd0);
    chk("t6_addr", imem_addr, BASE);
    chk("t6_wdata", imem_wdata, 32'd0);
    chk("t6_ready", {31'd0, in_ready}, 32'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    send_load(s1, 0);
    chk("t6_final_done", {31'd0, done}, 32'd1);
    tick();
    chk("t6_writes", we_count, 32'd2);
    chk("t6_sb_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
